// File: rtl/kernel_window_gen.sv
// Sliding KxK window generator with stride S over a raster pixel stream, backed by K-1 RAM line buffers.
// Optional KERNEL_WINDOW_OUT_COUNT_EN adds Out_Count, the running number of windows emitted in the frame.
module kernel_window_gen #(
   parameter int DATA_WIDHT  = 32,
   parameter int IMG_WIDHT   = 220,
   parameter int IMG_HEIGHT  = 220,
   parameter int KERNEL_SIZE = 3,
   parameter int STRIDE      = 1
) (
   input  logic                                              clk,
   input  logic                                              rst,
   input  logic [DATA_WIDHT-1:0]                             Data_In,
   input  logic                                              Valid_in,
   output logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDHT-1:0]     Data_Out,
   output logic                                              Valid_Out,
   output logic                                              Frame_Done
`ifdef KERNEL_WINDOW_OUT_COUNT_EN
   ,
   output logic [15:0]                                       Out_Count
`endif
);

   localparam int K  = KERNEL_SIZE;
   localparam int DW = DATA_WIDHT;
   localparam int CW = (IMG_WIDHT > 1) ? $clog2(IMG_WIDHT) : 1;
   localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
   localparam int PW = 3;
   localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDHT - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
   localparam logic [CW-1:0] COL_K    = CW'(K - 1);
   localparam logic [RW-1:0] ROW_K    = RW'(K - 1);
   localparam logic [PW-1:0] PH_LAST  = PW'(STRIDE - 1);

   logic              accept;
   logic [CW-1:0]     col_reg, col_next, rd_addr;
   logic [RW-1:0]     row_reg, row_next;
   logic [PW-1:0]     col_ph_reg, col_ph_next;
   logic [PW-1:0]     row_ph_reg, row_ph_next;
   logic              col_wrap, row_wrap, col_in, row_in;
   logic              emit, frame_end;
   logic              valid_out_reg, frame_done_reg;
   logic [K*K*DW-1:0] data_out_reg;
   logic [K*K*DW-1:0] win_flat;

   function automatic logic [PW-1:0] ph_inc(input logic [PW-1:0] p);
      return (p == PH_LAST) ? '0 : p + 1'b1;
   endfunction

   assign accept    = rst & Valid_in;
   assign col_wrap  = (col_reg == COL_LAST);
   assign row_wrap  = (row_reg == ROW_LAST);
   assign col_in    = (col_reg >= COL_K);
   assign row_in    = (row_reg >= ROW_K);
   assign emit      = accept & col_in & row_in & (col_ph_reg == '0) & (row_ph_reg == '0);
   assign frame_end = accept & col_wrap & row_wrap;

   // Phase counters track (pos-(K-1)) mod S; they sit at 0 until the first window position.
   always_comb begin
      col_next    = col_reg;
      row_next    = row_reg;
      col_ph_next = col_ph_reg;
      row_ph_next = row_ph_reg;
      if (accept) begin
         if (col_wrap) begin
            col_next    = '0;
            col_ph_next = '0;
            if (row_wrap) begin
               row_next    = '0;
               row_ph_next = '0;
            end else begin
               row_next    = row_reg + 1'b1;
               row_ph_next = row_in ? ph_inc(row_ph_reg) : '0;
            end
         end else begin
            col_next    = col_reg + 1'b1;
            col_ph_next = col_in ? ph_inc(col_ph_reg) : '0;
         end
      end
   end

   // RAM read is registered, so it is issued one pixel ahead at the column about to arrive.
   assign rd_addr = rst ? col_next : '0;

   always_ff @(posedge clk) begin
      if (!rst) begin
         col_reg        <= '0;
         row_reg        <= '0;
         col_ph_reg     <= '0;
         row_ph_reg     <= '0;
         valid_out_reg  <= 1'b0;
         frame_done_reg <= 1'b0;
         data_out_reg   <= '0;
      end else begin
         col_reg        <= col_next;
         row_reg        <= row_next;
         col_ph_reg     <= col_ph_next;
         row_ph_reg     <= row_ph_next;
         valid_out_reg  <= emit;
         frame_done_reg <= frame_end;
         if (emit)
            data_out_reg <= win_flat;
      end
   end

   genvar gi, gj;
   generate
      if (K > 1) begin : g_lines
         logic [(K-1)*DW-1:0] tap_bus;

         for (gi = 0; gi < K-1; gi++) begin : g_lb
            logic [DW-1:0] mem [0:IMG_WIDHT-1];
            logic [DW-1:0] rd_reg;
            logic [DW-1:0] wr_data;
            if (gi == 0) begin : g_first
               assign wr_data = Data_In;
            end else begin : g_chain
               assign wr_data = tap_bus[(gi-1)*DW +: DW];
            end
            always_ff @(posedge clk) begin
               if (accept)
                  mem[col_reg] <= wr_data;
               rd_reg <= mem[rd_addr];
            end
            assign tap_bus[gi*DW +: DW] = rd_reg;
         end

         // Row 0 of the window is the oldest line, i.e. the deepest line buffer tap.
         for (gi = 0; gi < K; gi++) begin : g_row
            logic [DW-1:0] col_new;
            logic [DW-1:0] hist_reg [0:K-2];
            if (gi == K-1) begin : g_newest
               assign col_new = Data_In;
            end else begin : g_older
               assign col_new = tap_bus[(K-2-gi)*DW +: DW];
            end
            always_ff @(posedge clk) begin
               if (accept) begin
                  for (int j = 0; j < K-2; j++)
                     hist_reg[j] <= hist_reg[j+1];
                  hist_reg[K-2] <= col_new;
               end
            end
            for (gj = 0; gj < K-1; gj++) begin : g_col
               assign win_flat[(gi*K+gj)*DW +: DW] = hist_reg[gj];
            end
            assign win_flat[(gi*K+K-1)*DW +: DW] = col_new;
         end
      end else begin : g_bypass
         assign win_flat = Data_In;
      end
   endgenerate

`ifdef KERNEL_WINDOW_OUT_COUNT_EN
   logic [15:0] out_count_reg, out_count_next;

   always_comb begin
      out_count_next = (frame_done_reg ? 16'd0 : out_count_reg) + {15'd0, emit};
   end

   always_ff @(posedge clk) begin
      if (!rst)
         out_count_reg <= '0;
      else
         out_count_reg <= out_count_next;
   end

   assign Out_Count = out_count_reg;
`endif

   assign Data_Out   = data_out_reg;
   assign Valid_Out  = valid_out_reg;
   assign Frame_Done = frame_done_reg;

endmodule

// File: tb/tb_kernel_window_gen.sv
// Directed bench for kernel_window_gen: four configurations, window tables checked against captured output.
module tb_kernel_window_gen;

   localparam int DW = 32;

   typedef struct {
      int         trig;
      logic       vo;
      logic       fd;
      logic [799:0] data;
      int         cnt;
   } rec_t;

   typedef struct {
      int trig;
      int tl;
      bit vo;
      bit fd;
      int cnt;
   } vec_t;

   logic clk;
   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic           rst_a, v_a, rst_b, v_b, rst_c, v_c;
   logic [DW-1:0]  d_a, d_b, d_c;
   logic [9*DW-1:0]  do_a1, do_a2;
   logic [DW-1:0]    do_b;
   logic [25*DW-1:0] do_c;
   logic vo_a1, fd_a1, vo_a2, fd_a2, vo_b, fd_b, vo_c, fd_c;
   int   cnt_a1;
`ifdef KERNEL_WINDOW_OUT_COUNT_EN
   logic [15:0] oc_a1, oc_a2, oc_b, oc_c;
   always_comb cnt_a1 = int'(oc_a1);
`else
   always_comb cnt_a1 = 0;
`endif

   kernel_window_gen #(.DATA_WIDHT(DW), .IMG_WIDHT(6), .IMG_HEIGHT(6), .KERNEL_SIZE(3), .STRIDE(1)) u_a1 (
      .clk(clk), .rst(rst_a), .Data_In(d_a), .Valid_in(v_a),
      .Data_Out(do_a1), .Valid_Out(vo_a1), .Frame_Done(fd_a1)
`ifdef KERNEL_WINDOW_OUT_COUNT_EN
      , .Out_Count(oc_a1)
`endif
   );

   kernel_window_gen #(.DATA_WIDHT(DW), .IMG_WIDHT(6), .IMG_HEIGHT(6), .KERNEL_SIZE(3), .STRIDE(2)) u_a2 (
      .clk(clk), .rst(rst_a), .Data_In(d_a), .Valid_in(v_a),
      .Data_Out(do_a2), .Valid_Out(vo_a2), .Frame_Done(fd_a2)
`ifdef KERNEL_WINDOW_OUT_COUNT_EN
      , .Out_Count(oc_a2)
`endif
   );

   kernel_window_gen #(.DATA_WIDHT(DW), .IMG_WIDHT(4), .IMG_HEIGHT(4), .KERNEL_SIZE(1), .STRIDE(1)) u_b (
      .clk(clk), .rst(rst_b), .Data_In(d_b), .Valid_in(v_b),
      .Data_Out(do_b), .Valid_Out(vo_b), .Frame_Done(fd_b)
`ifdef KERNEL_WINDOW_OUT_COUNT_EN
      , .Out_Count(oc_b)
`endif
   );

   kernel_window_gen #(.DATA_WIDHT(DW), .IMG_WIDHT(8), .IMG_HEIGHT(8), .KERNEL_SIZE(5), .STRIDE(1)) u_c (
      .clk(clk), .rst(rst_c), .Data_In(d_c), .Valid_in(v_c),
      .Data_Out(do_c), .Valid_Out(vo_c), .Frame_Done(fd_c)
`ifdef KERNEL_WINDOW_OUT_COUNT_EN
      , .Out_Count(oc_c)
`endif
   );

   int checks = 0;
   int errors = 0;
   rec_t q_a1[$], q_a2[$], q_b[$], q_c[$], got[$];
   vec_t tab[$];

   // Which pixel (if any) was accepted on the most recent rising edge.
   int pix_a, pix_b, pix_c;
   bit acc_a, acc_b, acc_c;
   always @(posedge clk) begin
      acc_a <= rst_a && v_a;  pix_a <= int'(d_a);
      acc_b <= rst_b && v_b;  pix_b <= int'(d_b);
      acc_c <= rst_c && v_c;  pix_c <= int'(d_c);
   end

   function automatic rec_t mk_rec(input int trig, input logic vo, input logic fd,
                                   input logic [799:0] data, input int cnt);
      rec_t r;
      r.trig = trig; r.vo = vo; r.fd = fd; r.data = data; r.cnt = cnt;
      return r;
   endfunction

   always @(negedge clk) begin
      if (vo_a1 || fd_a1) q_a1.push_back(mk_rec(acc_a ? pix_a : -1, vo_a1, fd_a1, 800'(do_a1), cnt_a1));
      if (vo_a2 || fd_a2) q_a2.push_back(mk_rec(acc_a ? pix_a : -1, vo_a2, fd_a2, 800'(do_a2), 0));
      if (vo_b || fd_b)   q_b.push_back(mk_rec(acc_b ? pix_b : -1, vo_b, fd_b, 800'(do_b), 0));
      if (vo_c || fd_c)   q_c.push_back(mk_rec(acc_c ? pix_c : -1, vo_c, fd_c, 800'(do_c), 0));
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic add(input int trig, input int tl, input bit vo, input bit fd, input int cnt);
      vec_t v;
      v.trig = trig; v.tl = tl; v.vo = vo; v.fd = fd; v.cnt = cnt;
      tab.push_back(v);
   endtask

   task automatic chk(input string name, input logic [799:0] act, input logic [799:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", name, act, exp);
      end else
         $display("ok %s = %0d", name, act);
   endtask

   // Compares captured records against tab; window element (r,c) must equal tl + r*w + c.
   task automatic check_run(input string name, input int k, input int w, input bit chk_cnt);
      int n;
      checks++;
      if (got.size() != tab.size()) begin
         errors++;
         $display("FAIL %s count got %0d expected %0d", name, got.size(), tab.size());
      end
      n = (got.size() < tab.size()) ? got.size() : tab.size();
      for (int i = 0; i < n; i++) begin
         logic [799:0] exp_d;
         bit bad;
         exp_d = '0;
         for (int r = 0; r < k; r++)
            for (int c = 0; c < k; c++)
               exp_d[(r*k+c)*32 +: 32] = 32'(tab[i].tl + r*w + c);
         bad = (got[i].trig != tab[i].trig) || (got[i].vo !== tab[i].vo) || (got[i].fd !== tab[i].fd);
         if (tab[i].vo && (got[i].data !== exp_d))
            bad = 1'b1;
         checks++;
         if (bad) begin
            errors++;
            $display("FAIL %s win %0d trig %0d exp %0d vo %0b exp %0b fd %0b exp %0b elem0 %0d exp %0d",
                     name, i, got[i].trig, tab[i].trig, got[i].vo, tab[i].vo, got[i].fd, tab[i].fd,
                     got[i].data[31:0], exp_d[31:0]);
         end else
            $display("%s win %0d trig %0d vo %0b fd %0b elem0 %0d", name, i, got[i].trig,
                     got[i].vo, got[i].fd, got[i].data[31:0]);
`ifdef KERNEL_WINDOW_OUT_COUNT_EN
         if (chk_cnt) begin
            checks++;
            if (got[i].cnt != tab[i].cnt) begin
               errors++;
               $display("FAIL %s out_count win %0d got %0d expected %0d", name, i, got[i].cnt, tab[i].cnt);
            end
         end
`endif
      end
   endtask

   task automatic load_k3s1();
      int t1 [16];
      t1 = '{14, 15, 16, 17, 20, 21, 22, 23, 26, 27, 28, 29, 32, 33, 34, 35};
      tab.delete();
      for (int i = 0; i < 16; i++)
         add(t1[i], t1[i] - 14, 1'b1, i == 15, i + 1);
   endtask

   task automatic load_k3s2();
      tab.delete();
      add(14, 0, 1'b1, 1'b0, 1);
      add(16, 2, 1'b1, 1'b0, 2);
      add(26, 12, 1'b1, 1'b0, 3);
      add(28, 14, 1'b1, 1'b0, 4);
      add(35, 0, 1'b0, 1'b1, 4);
   endtask

   initial begin
      int t5 [16];
      t5 = '{36, 37, 38, 39, 44, 45, 46, 47, 52, 53, 54, 55, 60, 61, 62, 63};
      rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
      v_a = 1'b1; v_b = 1'b1; v_c = 1'b1;
      d_a = 32'd7; d_b = 32'd7; d_c = 32'd7;
      repeat (3) step();

      chk("reset_a1", 800'({do_a1, vo_a1, fd_a1}), 800'd0);
      chk("reset_a2", 800'({do_a2, vo_a2, fd_a2}), 800'd0);
      chk("reset_b",  800'({do_b, vo_b, fd_b}), 800'd0);
      chk("reset_c",  800'({do_c, vo_c, fd_c}), 800'd0);
`ifdef KERNEL_WINDOW_OUT_COUNT_EN
      chk("reset_out_count", 800'(oc_a1), 800'd0);
`endif
      v_a = 1'b0; v_b = 1'b0; v_c = 1'b0;
      rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
      step();
      q_a1.delete(); q_a2.delete(); q_b.delete(); q_c.delete();

      // Continuous 6x6 frame into the K=3 S=1 and K=3 S=2 instances.
      for (int p = 0; p < 36; p++) begin
         d_a = 32'(p); v_a = 1'b1; step();
      end
      v_a = 1'b0;
      step(); step();
`ifdef KERNEL_WINDOW_OUT_COUNT_EN
      chk("out_count_gap", 800'(oc_a1), 800'd0);
`endif
      got = q_a1; load_k3s1(); check_run("k3s1", 3, 6, 1'b1);
      got = q_a2; load_k3s2(); check_run("k3s2", 3, 6, 1'b0);
      chk("k3s2_hold_e0", 800'(do_a2[31:0]), 800'd14);
      chk("k3s2_hold_e8", 800'(do_a2[8*32 +: 32]), 800'd28);
      q_a1.delete(); q_a2.delete();

      // Second frame with Valid_in toggling and a long gap across the row 1 -> row 2 wrap.
      for (int p = 0; p < 36; p++) begin
         d_a = 32'(p); v_a = 1'b1; step();
         v_a = 1'b0; step();
         if (p == 11) repeat (5) step();
      end
      step();
      got = q_a1; load_k3s1(); check_run("k3s1_gaps", 3, 6, 1'b1);
      got = q_a2; load_k3s2(); check_run("k3s2_gaps", 3, 6, 1'b0);

      // K=1 pass-through.
      for (int i = 0; i < 16; i++) begin
         d_b = 32'(100 + i); v_b = 1'b1; step();
      end
      v_b = 1'b0;
      step(); step();
      tab.delete();
      for (int i = 0; i < 16; i++)
         add(100 + i, 100 + i, 1'b1, i == 15, i + 1);
      got = q_b; check_run("k1", 1, 4, 1'b0);

      // K=5: abort mid-frame with a pixel presented during reset, then two clean frames.
      for (int p = 0; p <= 40; p++) begin
         d_c = 32'(p); v_c = 1'b1; step();
      end
      rst_c = 1'b0; d_c = 32'd41; v_c = 1'b1;
      step();
      chk("k5_abort_valid", 800'({vo_c, fd_c}), 800'd0);
      chk("k5_abort_data", 800'(do_c), 800'd0);
      q_c.delete();
      rst_c = 1'b1;
      for (int f = 0; f < 2; f++)
         for (int p = 0; p < 64; p++) begin
            d_c = 32'(p); v_c = 1'b1; step();
         end
      v_c = 1'b0;
      step(); step();
      tab.delete();
      for (int f = 0; f < 2; f++)
         for (int i = 0; i < 16; i++)
            add(t5[i], t5[i] - 36, 1'b1, i == 15, i + 1);
      got = q_c; check_run("k5", 5, 8, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
